// File: rtl/lane_stim_pkg.sv
// Shared types and constants for the lane stimulus generator and its per-lane pattern engines.
package lane_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } modeT;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BURST,
        GAP,
        FIN
    } stateT;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lane_pattern.sv
// Per-lane pattern engine: word is the value this lane holds after the current cycle,
// so the top can register it into data_out on the same edge it is loaded or advanced.
module lane_pattern
    import lane_stim_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS),
    parameter int                LANE      = 0
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  modeT              mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] word
);

    localparam logic [DATA_W-1:0] LANE_IDX  = DATA_W'(LANE);
    localparam logic [DATA_W-1:0] WALK_INIT = DATA_W'(1) << (LANE % DATA_W);

    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] initWord;
    logic [DATA_W-1:0] stepWord;
    logic [DATA_W-1:0] lfsrInit;

    always_comb begin
        lfsrInit = seed ^ LANE_IDX;
        initWord = seed + LANE_IDX;
        stepWord = cur;
        word     = cur;

        case (mode)
            MODE_CONST, MODE_INCR: initWord = seed + LANE_IDX;
            // an all-zero LFSR state would lock up, so it is forced to 1
            MODE_LFSR:             initWord = (lfsrInit == '0) ? DATA_W'(1) : lfsrInit;
            default:               initWord = WALK_INIT;
        endcase

        case (mode)
            MODE_CONST: stepWord = cur;
            MODE_INCR:  stepWord = cur + DATA_W'(1);
            MODE_LFSR:  stepWord = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
            default:    stepWord = {cur[DATA_W-2:0], cur[DATA_W-1]};
        endcase

        if (load) begin
            word = initWord;
        end else if (advance) begin
            word = stepWord;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cur <= '0;
        end else begin
            cur <= word;
        end
    end

endmodule

// File: rtl/lane_stim_gen.sv
// Divided clocks from clk_32f plus per-lane data/valid bursts aligned to clk_f rising edges.
// state | meaning
// IDLE  | waiting for start
// ARM   | config captured, waiting for the next clk_f rise
// BURST | one pattern word per clk_f period
// GAP   | idle clk_f periods between bursts
// FIN   | one-cycle done pulse, then back to IDLE
module lane_stim_gen
    import lane_stim_pkg::*;
#(
    parameter int                LANES      = 4,
    parameter int                DATA_W     = 8,
    parameter int                RATIO_LOG2 = 5,
    parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(DEFAULT_LFSR_TAPS)
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [7:0]              burst_len,
    input  logic [7:0]              gap_len,
    input  logic [7:0]              num_bursts,
    input  logic [LANES-1:0]        lane_en,
    input  logic [DATA_W-1:0]       seed,
    output logic                    clk_f,
    output logic                    clk_2f,
    output logic                    clk_4f,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic                    busy,
    output logic                    done
);

    localparam int MSB = RATIO_LOG2 - 1;

    stateT                   state, stateNext;
    logic [RATIO_LOG2-1:0]   cnt, cntNext;
    logic                    tick;

    modeT                    cfgMode;
    logic [7:0]              cfgBurstLen, cfgGapLen, cfgNumBursts;
    logic [LANES-1:0]        cfgLaneEn;
    logic [DATA_W-1:0]       cfgSeed;

    logic [7:0]              beatCnt, beatNext;
    logic [7:0]              gapCnt, gapNext;
    logic [7:0]              burstCnt, burstNext;

    logic                    capture, loadPat, advPat, showWord, clearOut;
    logic [LANES*DATA_W-1:0] patWords;

    assign cntNext = cnt + 1'b1;
    assign tick    = &cnt;

    for (genvar g = 0; g < LANES; g++) begin : gLane
        lane_pattern #(
            .DATA_W   (DATA_W),
            .LFSR_TAPS(LFSR_TAPS),
            .LANE     (g)
        ) uPattern (
            .clk_32f(clk_32f),
            .reset  (reset),
            .load   (loadPat),
            .advance(advPat),
            .mode   (cfgMode),
            .seed   (cfgSeed),
            .word   (patWords[g*DATA_W +: DATA_W])
        );
    end

    // beatCnt/gapCnt/burstCnt count what remains after the current period
    always_comb begin
        stateNext = state;
        beatNext  = beatCnt;
        gapNext   = gapCnt;
        burstNext = burstCnt;
        capture   = 1'b0;
        loadPat   = 1'b0;
        advPat    = 1'b0;
        showWord  = 1'b0;
        clearOut  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    stateNext = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    loadPat   = 1'b1;
                    showWord  = 1'b1;
                    beatNext  = cfgBurstLen - 8'd1;
                    burstNext = cfgNumBursts - 8'd1;
                    stateNext = BURST;
                end
            end
            BURST: begin
                if (tick) begin
                    advPat = 1'b1;
                    if (beatCnt != 8'd0) begin
                        beatNext = beatCnt - 8'd1;
                        showWord = 1'b1;
                    end else if (burstCnt == 8'd0) begin
                        clearOut  = 1'b1;
                        stateNext = FIN;
                    end else begin
                        burstNext = burstCnt - 8'd1;
                        if (cfgGapLen == 8'd0) begin
                            showWord = 1'b1;
                            beatNext = cfgBurstLen - 8'd1;
                        end else begin
                            clearOut  = 1'b1;
                            gapNext   = cfgGapLen - 8'd1;
                            stateNext = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gapCnt == 8'd0) begin
                        showWord  = 1'b1;
                        beatNext  = cfgBurstLen - 8'd1;
                        stateNext = BURST;
                    end else begin
                        gapNext = gapCnt - 8'd1;
                    end
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt          <= '0;
            clk_f        <= 1'b1;
            clk_2f       <= 1'b1;
            clk_4f       <= 1'b1;
            state        <= IDLE;
            cfgMode      <= MODE_CONST;
            cfgBurstLen  <= '0;
            cfgGapLen    <= '0;
            cfgNumBursts <= '0;
            cfgLaneEn    <= '0;
            cfgSeed      <= '0;
            beatCnt      <= '0;
            gapCnt       <= '0;
            burstCnt     <= '0;
            data_out     <= '0;
            valid_out    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cnt      <= cntNext;
            clk_f    <= ~cntNext[MSB];
            clk_2f   <= ~cntNext[MSB-1];
            clk_4f   <= ~cntNext[MSB-2];
            state    <= stateNext;
            beatCnt  <= beatNext;
            gapCnt   <= gapNext;
            burstCnt <= burstNext;
            done     <= (stateNext == FIN);

            if (capture) begin
                cfgMode      <= modeT'(mode);
                cfgBurstLen  <= (burst_len == 8'd0) ? 8'd1 : burst_len;
                cfgGapLen    <= gap_len;
                cfgNumBursts <= (num_bursts == 8'd0) ? 8'd1 : num_bursts;
                cfgLaneEn    <= lane_en;
                cfgSeed      <= seed;
                busy         <= 1'b1;
            end else if (stateNext == FIN) begin
                busy <= 1'b0;
            end

            if (showWord) begin
                data_out  <= patWords;
                valid_out <= cfgLaneEn;
            end else if (clearOut) begin
                data_out  <= '0;
                valid_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lane_stim_gen.sv
// Self-checking bench for lane_stim_gen: directed and randomized runs against a
// period-indexed reference model of the burst schedule and lane patterns.
module tb_lane_stim_gen;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  burst_len = '0;
    logic [7:0]  gap_len = '0;
    logic [7:0]  num_bursts = '0;
    logic [3:0]  lane_en = '0;
    logic [7:0]  seed = '0;
    logic        clk_f, clk_2f, clk_4f;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        busy, done;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  refCnt = '0;
    logic [7:0]  laneZeroFirst, laneZeroSecond;

    lane_stim_gen dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .num_bursts(num_bursts),
        .lane_en   (lane_en),
        .seed      (seed),
        .clk_f     (clk_f),
        .clk_2f    (clk_2f),
        .clk_4f    (clk_4f),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_32f = ~clk_32f;

    // position within the clk_f period; 0 means this edge was a clk_f rise
    always @(posedge clk_32f) begin
        if (reset) refCnt <= '0;
        else       refCnt <= refCnt + 5'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lane word at the k-th burst beat of a run (beats counted across bursts, gaps excluded)
    function automatic logic [7:0] refWord(input int md, input logic [7:0] sd, input int lane, input int k);
        logic [7:0] v;
        case (md)
            0: v = sd + 8'(lane);
            1: v = sd + 8'(lane) + 8'(k);
            2: begin
                v = sd ^ 8'(lane);
                if (v == 8'd0) v = 8'd1;
                for (int j = 0; j < k; j++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
            end
            default: begin
                v = 8'd1 << (lane % 8);
                for (int j = 0; j < k % 8; j++) v = (v << 1) | (v >> 7);
            end
        endcase
        return v;
    endfunction

    task automatic waitRise();
        do begin
            @(posedge clk_32f);
            #1;
        end while (refCnt != 5'd0);
    endtask

    task automatic runCheck(input string name, input int md, input logic [7:0] sd, input int bl,
                            input int gl, input int nb, input logic [3:0] en, input bit align,
                            input bit poke);
        int          blE, nbE, total, b, r, k;
        logic [31:0] expData;
        logic [3:0]  expValid;
        blE   = (bl == 0) ? 1 : bl;
        nbE   = (nb == 0) ? 1 : nb;
        total = nbE * blE + (nbE - 1) * gl;

        repeat ($urandom_range(0, 40)) @(posedge clk_32f);
        #1;
        if (align) begin
            while (refCnt != 5'd31) begin
                @(posedge clk_32f);
                #1;
            end
        end
        mode       = md[1:0];
        seed       = sd;
        burst_len  = bl[7:0];
        gap_len    = gl[7:0];
        num_bursts = nb[7:0];
        lane_en    = en;
        start      = 1'b1;
        @(posedge clk_32f);
        #1;
        start      = 1'b0;
        mode       = 2'($urandom);
        seed       = 8'($urandom);
        burst_len  = 8'($urandom);
        gap_len    = 8'($urandom);
        num_bursts = 8'($urandom);
        lane_en    = 4'($urandom);
        check({name, " accept valid"}, 32'(valid_out), 32'd0);
        check({name, " accept busy"}, 32'(busy), 32'd1);

        for (int p = 0; p < total; p++) begin
            waitRise();
            b = p / (blE + gl);
            r = p % (blE + gl);
            expData  = '0;
            expValid = '0;
            if (r < blE) begin
                k        = b * blE + r;
                expValid = en;
                for (int l = 0; l < 4; l++) expData[l*8 +: 8] = refWord(md, sd, l, k);
            end
            check({name, " valid"}, 32'(valid_out), 32'(expValid));
            check({name, " data"}, data_out, expData);
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " done early"}, 32'(done), 32'd0);
            if (p == 0) laneZeroFirst = data_out[7:0];
            if (p == 1) laneZeroSecond = data_out[7:0];
            if (poke && p == 0) start = 1'b1;
            @(posedge clk_32f);
            #1;
            start = 1'b0;
            repeat (30) @(posedge clk_32f);
            #1;
            check({name, " held data"}, data_out, expData);
        end

        waitRise();
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " fin valid"}, 32'(valid_out), 32'd0);
        check({name, " fin data"}, data_out, 32'd0);
        check({name, " fin busy"}, 32'(busy), 32'd0);
        @(posedge clk_32f);
        #1;
        check({name, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit doneSeen, validSeen;

        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        check("rst clk_f", 32'(clk_f), 32'd1);
        check("rst clk_2f", 32'(clk_2f), 32'd1);
        check("rst clk_4f", 32'(clk_4f), 32'd1);
        check("rst valid", 32'(valid_out), 32'd0);
        check("rst data", data_out, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int c = 0; c < 64; c++) begin
            @(posedge clk_32f);
            #1;
            check("div clk_f", 32'(clk_f), 32'(!refCnt[4]));
            check("div clk_2f", 32'(clk_2f), 32'(!refCnt[3]));
            check("div clk_4f", 32'(clk_4f), 32'(!refCnt[2]));
            check("idle valid", 32'(valid_out), 32'd0);
            check("idle data", data_out, 32'd0);
        end

        runCheck("incr", 1, 8'hBB, 3, 0, 1, 4'hF, 1'b0, 1'b0);
        check("incr lane0 first", 32'(laneZeroFirst), 32'h000000BB);
        check("incr lane0 second", 32'(laneZeroSecond), 32'h000000BC);

        runCheck("lfsr", 2, 8'h00, 2, 0, 1, 4'b0100, 1'b0, 1'b0);
        check("lfsr lane0 first", 32'(laneZeroFirst), 32'h00000001);
        check("lfsr lane0 second", 32'(laneZeroSecond), 32'h000000B8);

        runCheck("walk", 3, 8'h00, 2, 2, 2, 4'hF, 1'b0, 1'b0);
        check("walk lane0 first", 32'(laneZeroFirst), 32'h00000001);
        check("walk lane0 second", 32'(laneZeroSecond), 32'h00000002);

        runCheck("zero lens", 1, 8'h10, 0, 3, 0, 4'hF, 1'b0, 1'b0);
        runCheck("busy start", 0, 8'h5A, 3, 1, 2, 4'hA, 1'b0, 1'b1);
        runCheck("start on tick", 1, 8'hFE, 2, 1, 2, 4'h3, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            runCheck("random", int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        mode       = 2'd1;
        seed       = 8'h20;
        burst_len  = 8'd5;
        gap_len    = 8'd0;
        num_bursts = 8'd1;
        lane_en    = 4'hF;
        start      = 1'b1;
        @(posedge clk_32f);
        #1;
        start = 1'b0;
        waitRise();
        waitRise();
        check("pre-reset valid", 32'(valid_out), 32'hF);
        repeat (7) @(posedge clk_32f);
        #1;
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        check("midrst valid", 32'(valid_out), 32'd0);
        check("midrst data", data_out, 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst clk_f", 32'(clk_f), 32'd1);
        reset = 1'b0;
        doneSeen  = 1'b0;
        validSeen = 1'b0;
        repeat (200) begin
            @(posedge clk_32f);
            #1;
            if (done) doneSeen = 1'b1;
            if (valid_out != 4'd0) validSeen = 1'b1;
        end
        check("midrst no done", 32'(doneSeen), 32'd0);
        check("midrst stays idle", 32'(validSeen), 32'd0);

        runCheck("after reset", 2, 8'h3C, 3, 1, 2, 4'h9, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
